// File: rtl/enemy_lane_controller_if.sv
// enemy_lane_controller_if
//   Bundles the game-side controls and the lane/player status of the enemy
//   lane controller.
//   master: drives start, tick, fire_state, lane_sel; observes the status.
//   slave : the controller; consumes the controls and drives enemy_state,
//           enemy_flag, hit, attack, player_hp and kill_count.
interface enemy_lane_controller_if #(
    parameter int unsigned LANES = 3
);
    logic             start;
    logic             tick;
    logic [2:0]       fire_state;
    logic [LANES-1:0] lane_sel;
    logic [2:0]       enemy_state;
    logic [LANES-1:0] enemy_flag;
    logic [LANES-1:0] hit;
    logic [LANES-1:0] attack;
    logic [3:0]       player_hp;
    logic [7:0]       kill_count;

    modport master (
        output start, tick, fire_state, lane_sel,
        input  enemy_state, enemy_flag, hit, attack, player_hp, kill_count
    );

    modport slave (
        input  start, tick, fire_state, lane_sel,
        output enemy_state, enemy_flag, hit, attack, player_hp, kill_count
    );
endinterface

// File: rtl/enemy_lane_controller.sv
// enemy_lane_controller
//   Runs LANES independent enemy lanes (spawn timer, health, attack timer),
//   resolves player shots against the lane the camera faces, and tracks
//   player health, game state and kills. Game time advances on bus.tick.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - slave side of enemy_lane_controller_if (controls in, status out)
module enemy_lane_controller #(
    parameter int unsigned LANES        = 3,
    parameter int unsigned HEALTH       = 3,
    parameter int unsigned SPAWN_BASE   = 5,
    parameter int unsigned SPAWN_STEP   = 3,
    parameter int unsigned ATTACK_TICKS = 4,
    parameter int unsigned PLAYER_HP    = 3,
    parameter int unsigned TIMER_W      = 6
) (
    input logic                     clk,
    input logic                     rst,
    enemy_lane_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        StInit = 3'b001,
        StRun  = 3'b010,
        StOver = 3'b100
    } state_e;

    localparam logic [TIMER_W-1:0] TimerOne = TIMER_W'(1);

    state_e state_q, state_d;

    logic [TIMER_W-1:0] spawn_q [LANES];
    logic [TIMER_W-1:0] spawn_d [LANES];
    logic [TIMER_W-1:0] atk_q   [LANES];
    logic [TIMER_W-1:0] atk_d   [LANES];
    logic [3:0]         health_q [LANES];
    logic [3:0]         health_d [LANES];

    logic [LANES-1:0] flag_q, flag_d;
    logic [LANES-1:0] hit_q, hit_d;
    logic [LANES-1:0] attack_q, attack_d;
    logic [3:0]       hp_q, hp_d;
    logic [7:0]       kill_q, kill_d;
    logic             fired_q;

    logic run;
    logic launch;
    logic shot;
    logic sel_onehot;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. hp_d is the post-attack health, so OVER is entered
    // on the same edge that player_hp reaches zero.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (bus.start) state_d = StRun;
            StRun:   if (hp_d == 4'd0) state_d = StOver;
            StOver:  if (bus.start) state_d = StInit;
            default: state_d = StInit;
        endcase
    end

    // FSM: outputs / control
    always_comb begin
        run             = (state_q == StRun);
        launch          = (state_q == StInit) && bus.start;
        bus.enemy_state = state_q;
    end

    // ------------------------------------------------------------------
    // Shot detection: a fire edge is a fresh 010; other codes clear history
    // ------------------------------------------------------------------
    always_comb begin
        sel_onehot = (bus.lane_sel != '0) &&
                     ((bus.lane_sel & (bus.lane_sel - LANES'(1))) == '0);
        shot       = (bus.fire_state == 3'b010) && !fired_q && sel_onehot;
    end

    // ------------------------------------------------------------------
    // Lane and player datapath
    // ------------------------------------------------------------------
    always_comb begin
        logic [3:0] n_atk;
        logic       killed;
        spawn_d  = spawn_q;
        atk_d    = atk_q;
        health_d = health_q;
        flag_d   = flag_q;
        hit_d    = '0;
        attack_d = '0;
        hp_d     = hp_q;
        kill_d   = kill_q;
        n_atk    = 4'd0;
        killed   = 1'b0;

        if (launch) begin
            for (int i = 0; i < int'(LANES); i++) begin
                spawn_d[i]  = TIMER_W'(SPAWN_BASE + i * SPAWN_STEP);
                atk_d[i]    = '0;
                health_d[i] = 4'd0;
            end
            flag_d = '0;
            hp_d   = 4'(PLAYER_HP);
            kill_d = 8'd0;
        end else if (run) begin
            for (int i = 0; i < int'(LANES); i++) begin
                killed = 1'b0;
                if (flag_q[i]) begin
                    // Hit first; a killing hit suppresses this lane's attack.
                    if (shot && bus.lane_sel[i]) begin
                        hit_d[i]    = 1'b1;
                        health_d[i] = health_q[i] - 4'd1;
                        if (health_q[i] == 4'd1) begin
                            killed     = 1'b1;
                            flag_d[i]  = 1'b0;
                            spawn_d[i] = TIMER_W'(SPAWN_BASE);
                            if (kill_q != 8'hFF) kill_d = kill_q + 8'd1;
                        end
                    end
                    if (!killed && bus.tick) begin
                        if (atk_q[i] == TimerOne) begin
                            attack_d[i] = 1'b1;
                            atk_d[i]    = TIMER_W'(ATTACK_TICKS);
                            n_atk       = n_atk + 4'd1;
                        end else if (atk_q[i] != '0) begin
                            atk_d[i] = atk_q[i] - TimerOne;
                        end
                    end
                end else if (bus.tick) begin
                    if (spawn_q[i] == TimerOne) begin
                        flag_d[i]   = 1'b1;
                        health_d[i] = 4'(HEALTH);
                        atk_d[i]    = TIMER_W'(ATTACK_TICKS);
                    end else if (spawn_q[i] != '0) begin
                        spawn_d[i] = spawn_q[i] - TimerOne;
                    end
                end
            end
            hp_d = (n_atk >= hp_q) ? 4'd0 : hp_q - n_atk;
            // Entering OVER: all enemies vanish.
            if (hp_d == 4'd0) flag_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LANES); i++) begin
                spawn_q[i]  <= '0;
                atk_q[i]    <= '0;
                health_q[i] <= 4'd0;
            end
            flag_q   <= '0;
            hit_q    <= '0;
            attack_q <= '0;
            hp_q     <= 4'(PLAYER_HP);
            kill_q   <= 8'd0;
            fired_q  <= 1'b0;
        end else begin
            spawn_q  <= spawn_d;
            atk_q    <= atk_d;
            health_q <= health_d;
            flag_q   <= flag_d;
            hit_q    <= hit_d;
            attack_q <= attack_d;
            hp_q     <= hp_d;
            kill_q   <= kill_d;
            fired_q  <= (bus.fire_state == 3'b010);
        end
    end

    assign bus.enemy_flag = flag_q;
    assign bus.hit        = hit_q;
    assign bus.attack     = attack_q;
    assign bus.player_hp  = hp_q;
    assign bus.kill_count = kill_q;

endmodule

// File: tb/tb_enemy_lane_controller.sv
module tb_enemy_lane_controller;
    localparam int unsigned LANES = 3;
    localparam logic [2:0]  S_INIT = 3'b001;
    localparam logic [2:0]  S_RUN  = 3'b010;
    localparam logic [2:0]  S_OVER = 3'b100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enemy_lane_controller_if #(.LANES(LANES)) bus ();

    enemy_lane_controller #(
        .LANES       (LANES),
        .HEALTH      (3),
        .SPAWN_BASE  (5),
        .SPAWN_STEP  (3),
        .ATTACK_TICKS(4),
        .PLAYER_HP   (3),
        .TIMER_W     (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [LANES-1:0] sel = '0;

    typedef struct packed {
        logic [2:0] flag;
        logic [2:0] atk;
        logic [3:0] hp;
        logic [2:0] st;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive one clock of inputs; return #1 after the edge that sampled them.
    task automatic cyc(input logic s, input logic t, input logic [2:0] f,
                       input logic [LANES-1:0] ls);
        bus.start      = s;
        bus.tick       = t;
        bus.fire_state = f;
        bus.lane_sel   = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 3'b001, sel);
    endtask

    task automatic tick1();
        idle(9);
        cyc(1'b0, 1'b1, 3'b001, sel);
    endtask

    task automatic shoot(input logic [LANES-1:0] ls);
        cyc(1'b0, 1'b0, 3'b001, ls);
        cyc(1'b0, 1'b0, 3'b010, ls);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " state"},  bus.enemy_state, S_INIT);
        check({tag, " flag"},   bus.enemy_flag, 0);
        check({tag, " hit"},    bus.hit, 0);
        check({tag, " attack"}, bus.attack, 0);
        check({tag, " hp"},     bus.player_hp, 3);
        check({tag, " kills"},  bus.kill_count, 0);
    endtask

    initial begin
        int hits;
        // Expected status after each tick of an unopposed game.
        tbl[0]  = '{3'b000, 3'b000, 4'd3, S_RUN};
        tbl[1]  = '{3'b000, 3'b000, 4'd3, S_RUN};
        tbl[2]  = '{3'b000, 3'b000, 4'd3, S_RUN};
        tbl[3]  = '{3'b000, 3'b000, 4'd3, S_RUN};
        tbl[4]  = '{3'b001, 3'b000, 4'd3, S_RUN};
        tbl[5]  = '{3'b001, 3'b000, 4'd3, S_RUN};
        tbl[6]  = '{3'b001, 3'b000, 4'd3, S_RUN};
        tbl[7]  = '{3'b011, 3'b000, 4'd3, S_RUN};
        tbl[8]  = '{3'b011, 3'b001, 4'd2, S_RUN};
        tbl[9]  = '{3'b011, 3'b000, 4'd2, S_RUN};
        tbl[10] = '{3'b111, 3'b000, 4'd2, S_RUN};
        tbl[11] = '{3'b111, 3'b010, 4'd1, S_RUN};
        tbl[12] = '{3'b000, 3'b001, 4'd0, S_OVER};

        // Reset
        rst = 1'b1;
        idle(2);
        check_reset("reset");
        rst = 1'b0;

        // Start, then a start held in RUN is ignored
        cyc(1'b1, 1'b0, 3'b001, sel);
        check("start state", bus.enemy_state, S_RUN);
        cyc(1'b1, 1'b0, 3'b001, sel);
        check("start in run", bus.enemy_state, S_RUN);
        check("start in run hp", bus.player_hp, 3);

        // Unopposed game: spawns, attacks, game over
        for (int i = 0; i < 13; i++) begin
            tick1();
            check($sformatf("t%0d flag", i + 1),   bus.enemy_flag, tbl[i].flag);
            check($sformatf("t%0d attack", i + 1), bus.attack, tbl[i].atk);
            check($sformatf("t%0d hp", i + 1),     bus.player_hp, tbl[i].hp);
            check($sformatf("t%0d state", i + 1),  bus.enemy_state, tbl[i].st);
            check($sformatf("t%0d hit", i + 1),    bus.hit, 0);
        end

        // OVER is frozen
        tick1();
        tick1();
        check("over state", bus.enemy_state, S_OVER);
        check("over flag", bus.enemy_flag, 0);
        check("over attack", bus.attack, 0);

        // Restart: OVER -> INIT -> RUN
        cyc(1'b1, 1'b0, 3'b001, sel);
        check("over->init", bus.enemy_state, S_INIT);
        cyc(1'b0, 1'b0, 3'b001, sel);
        check("init hold", bus.enemy_state, S_INIT);
        cyc(1'b1, 1'b0, 3'b001, sel);
        check("restart state", bus.enemy_state, S_RUN);
        check("restart hp", bus.player_hp, 3);
        check("restart kills", bus.kill_count, 0);
        check("restart flag", bus.enemy_flag, 0);

        // Game 2: kill lane0 with three shots, middle one held 20 clocks
        repeat (5) tick1();
        check("g2 lane0 spawn", bus.enemy_flag, 3'b001);
        shoot(3'b001);
        check("shot1 hit", bus.hit, 3'b001);
        idle(1);
        check("shot1 pulse end", bus.hit, 0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 3'b010, 3'b001);
            hits += int'(bus.hit[0]);
        end
        check("held fire hits", hits, 1);
        check("held fire flag", bus.enemy_flag, 3'b001);
        shoot(3'b001);
        check("shot3 hit", bus.hit, 3'b001);
        check("shot3 flag", bus.enemy_flag, 3'b000);
        check("shot3 kills", bus.kill_count, 1);
        idle(1);

        // Respawn 5 ticks after the kill
        repeat (4) tick1();
        check("g2 t9 flag", bus.enemy_flag, 3'b010);
        tick1();
        check("g2 t10 flag", bus.enemy_flag, 3'b011);
        check("g2 t10 hp", bus.player_hp, 3);

        // Non-one-hot selection and empty lane: no effect
        shoot(3'b011);
        check("sel 011 hit", bus.hit, 0);
        idle(1);
        shoot(3'b100);
        check("empty lane hit", bus.hit, 0);
        idle(1);
        shoot(3'b001);
        check("lane0 r2 hit1", bus.hit, 3'b001);
        idle(1);
        shoot(3'b001);
        check("lane0 r2 alive", bus.enemy_flag, 3'b011);
        idle(1);
        shoot(3'b001);
        check("lane0 r2 dead", bus.enemy_flag, 3'b010);
        check("kills 2", bus.kill_count, 2);
        idle(1);

        // Wound lane1 twice, then kill it on its attack tick
        sel = 3'b010;
        shoot(3'b010);
        check("lane1 hit1", bus.hit, 3'b010);
        idle(1);
        shoot(3'b010);
        check("lane1 hit2", bus.hit, 3'b010);
        tick1();
        check("g2 t11 flag", bus.enemy_flag, 3'b110);
        check("g2 t11 attack", bus.attack, 0);
        idle(9);
        cyc(1'b0, 1'b1, 3'b010, 3'b010);
        check("kill vs attack hit", bus.hit, 3'b010);
        check("kill vs attack atk", bus.attack, 0);
        check("kill vs attack hp", bus.player_hp, 3);
        check("kill vs attack kills", bus.kill_count, 3);
        check("kill vs attack flag", bus.enemy_flag, 3'b100);
        idle(1);

        // Mid-game reset
        rst = 1'b1;
        idle(1);
        check_reset("midrst");
        rst = 1'b0;
        cyc(1'b1, 1'b0, 3'b001, sel);
        check("post-rst start", bus.enemy_state, S_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/enemy_lane_controller.md
# enemy_lane_controller

Parametrised enemy controller for the Doom game core: manages `LANES` independent enemy lanes, each with its own spawn timer, health counter and attack timer, and resolves player shots from the weapon FSM against the lane selected by the camera. Game-time advances on a single-cycle `tick` enable (one per game second), so the whole block runs on the system clock. Adds player health, a game-over state, per-lane hit/attack pulses and a kill counter.

## Interface
- `LANES`, 3: number of enemy lanes (camera directions), 1..8
- `HEALTH`, 3: hits needed to kill a freshly spawned enemy, 1..15
- `SPAWN_BASE`, 5: ticks from lane-empty to spawn
- `SPAWN_STEP`, 3: extra initial delay per lane index at game start
- `ATTACK_TICKS`, 4: ticks between attacks of a live enemy
- `PLAYER_HP`, 3: player hit points at game start, 1..15
- `TIMER_W`, 6: width of spawn/attack timers; all load values must fit

- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: start/restart request, level sampled each clock
- `tick` in 1: one-clock game-second enable
- `fire_state` in 3: weapon FSM state, one-hot: 001 loaded, 010 fired, 100 idle
- `lane_sel` in LANES: one-hot lane the camera faces
- `enemy_state` out 3: 001 INIT, 010 RUN, 100 OVER
- `enemy_flag` out LANES: enemy alive in lane i
- `hit` out LANES: one-clock pulse, shot landed on lane i
- `attack` out LANES: one-clock pulse, lane i enemy attacked
- `player_hp` out 4: remaining player hit points
- `kill_count` out 8: enemies killed this game, saturates at 255

## Operation
- FSM: INIT -> RUN when `start`=1; RUN -> OVER when `player_hp` becomes 0; OVER -> INIT when `start`=1; `start` ignored in RUN.
- On INIT->RUN edge: lane i spawn timer := SPAWN_BASE + i*SPAWN_STEP, `player_hp` := PLAYER_HP, `kill_count` := 0, all flags/health cleared.
- Spawn (RUN only): empty lane decrements its spawn timer on `tick`; on a tick with timer==1 the lane spawns: flag := 1, health := HEALTH, attack timer := ATTACK_TICKS.
- Shot: fire edge = `fire_state`==010 and previous-cycle `fire_state`!=010. Holding 010 fires once. Non-one-hot `fire_state` values are ignored and do not count as "previous fired".
- Shot applies only in RUN, only if `lane_sel` is exactly one-hot and that lane is alive: health -1, `hit[i]` pulses. Health reaching 0: flag := 0, `kill_count` +1 (saturating), spawn timer := SPAWN_BASE.
- Attack: alive lane decrements attack timer on `tick`; on a tick with timer==1: `attack[i]` pulses, timer := ATTACK_TICKS, `player_hp` decreases by 1 per attacking lane, saturating at 0.
- Same-cycle hit and attack on one lane: hit resolved first; if the hit kills, the attack is suppressed.
- In INIT and OVER: timers frozen, no spawns, hits or attacks; flags cleared on entry to OVER.

## Timing
- Reset values: `enemy_state`=001, `enemy_flag`=0, `hit`=0, `attack`=0, `player_hp`=PLAYER_HP, `kill_count`=0, all timers/health 0, fire history = not fired.
- All outputs registered; every effect appears one clock after the qualifying input edge.
- `hit`/`attack` high for exactly one clock per event.
- `enemy_state` changes to 100 on the same edge `player_hp` becomes 0.
- `rst` mid-game overrides everything on the next edge; returns to INIT.
- Spawn timers count only ticks; no clocks between ticks alter state except shots.

## Test plan
- Reset then `start` pulse, tick every 10 clocks, defaults -> lane0 flag rises after tick 5, lane1 after tick 8, lane2 after tick 11; `enemy_state`=010.
- Lane0 alive, `lane_sel`=001, three separate 001->010 edges -> `hit[0]` pulses 3x, flag falls on third, `kill_count`=1, lane0 respawns 5 ticks later.
- `fire_state` held at 010 for 20 clocks -> single hit; `lane_sel`=011 or `lane_sel` facing empty lane -> no hit, no health change.
- No shots, defaults -> lane0 `attack[0]` 4 ticks after spawn; with lanes 1,2 attacking later, `player_hp` 3->0, `enemy_state`=100, flags 0; `start` -> 001, next `start` -> 010, `player_hp`=3, `kill_count`=0.
- Killing shot on same clock as lane's attack tick with timer==1 -> `hit` pulses, `attack` stays 0, `player_hp` unchanged.
- `rst` asserted mid-RUN with enemies alive -> next edge all outputs at reset values, `enemy_state`=001.
